// File: rtl/ir_prefetch_queue_pkg.sv
// Shared defaults, reset opcode, IR action encoding and parity helper for the
// instruction prefetch queue.
package ir_pkg;

  localparam int IR_WORD_W    = 8;
  localparam int IR_DEPTH     = 4;
  localparam int PARITY_MAX_W = 64;

  localparam logic [7:0] NOP_OPCODE = 8'h00;

  typedef enum logic [2:0] {
    IR_HOLD,
    IR_FLUSH,
    IR_POP,
    IR_BYPASS,
    IR_STARVE
  } ir_action_e;

  // Callers zero-extend narrower words; zero padding leaves parity unchanged.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ir_prefetch_queue_fifo_mem.sv
// Prefetch storage array: falling-edge write port, asynchronous read port.
module ir_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(negedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ir_prefetch_queue.sv
// Prefetch FIFO feeding the architected instruction register; state updates on
// the falling clock edge. Optional per-entry parity via IR_PREFETCH_PARITY_EN.
module ir_prefetch_queue
  import ir_pkg::*;
#(
  parameter int WORD_W = IR_WORD_W,
  parameter int DEPTH  = IR_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [WORD_W-1:0]          wr_data,
  input  logic                       advance,
  input  logic                       flush,
  output logic [WORD_W-1:0]          ir_out,
  output logic                       ir_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
`ifdef IR_PREFETCH_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef IR_PREFETCH_PARITY_EN
  localparam int MEM_W = WORD_W + 1;
`else
  localparam int MEM_W = WORD_W;
`endif

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              ovf_q, ovf_d;
  logic              is_empty, is_full;
  logic              push, pop;
  ir_action_e        action;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;
`ifdef IR_PREFETCH_PARITY_EN
  logic              perr_q, perr_d;
`endif

  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CNT_W'(DEPTH));
    action   = IR_HOLD;
    pop      = 1'b0;
    if (flush) begin
      action = IR_FLUSH;
    end else if (advance) begin
      if (!is_empty) begin
        action = IR_POP;
        pop    = 1'b1;
      end else if (load) begin
        action = IR_BYPASS;
      end else begin
        action = IR_STARVE;
      end
    end
    // A full queue still accepts a push when the same edge pops the head.
    push = !flush && load && (action != IR_BYPASS) && (!is_full || pop);
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ovf_d      = ovf_q;
`ifdef IR_PREFETCH_PARITY_EN
    perr_d     = perr_q;
`endif
    unique case (action)
      IR_FLUSH: begin
        rd_ptr_d   = '0;
        wr_ptr_d   = '0;
        count_d    = '0;
        ir_valid_d = 1'b0;
`ifdef IR_PREFETCH_PARITY_EN
        perr_d     = 1'b0;
`endif
      end
      IR_POP: begin
        ir_d       = mem_rdata[WORD_W-1:0];
        ir_valid_d = 1'b1;
`ifdef IR_PREFETCH_PARITY_EN
        perr_d     = ^mem_rdata;
`endif
      end
      IR_BYPASS: begin
        ir_d       = wr_data;
        ir_valid_d = 1'b1;
`ifdef IR_PREFETCH_PARITY_EN
        perr_d     = 1'b0;
`endif
      end
      IR_STARVE: ir_valid_d = 1'b0;
      default: ;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
    if (!flush && load && is_full && !advance) ovf_d = 1'b1;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ir_q       <= WORD_W'(NOP_OPCODE);
      ir_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef IR_PREFETCH_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      ovf_q      <= ovf_d;
`ifdef IR_PREFETCH_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

`ifdef IR_PREFETCH_PARITY_EN
  assign mem_wdata  = {even_parity(PARITY_MAX_W'(wr_data)), wr_data};
  assign parity_err = perr_q;
`else
  assign mem_wdata  = wr_data;
`endif

  ir_fifo_mem #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign ir_out   = ir_q;
  assign ir_valid = ir_valid_q;
  assign count    = count_q;
  assign full     = is_full;
  assign empty    = is_empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Scoreboard bench for ir_prefetch_queue (DEPTH=4, WORD_W=8); parity scenario
// runs only when IR_PREFETCH_PARITY_EN is defined.
module tb_ir_prefetch_queue;

  localparam int WORD_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load = 1'b0;
  logic              advance = 1'b0;
  logic              flush = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic [WORD_W-1:0] ir_out;
  logic              ir_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
`ifdef IR_PREFETCH_PARITY_EN
  logic              parity_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [WORD_W-1:0] sb[$];
  logic [WORD_W-1:0] exp_ir    = '0;
  logic              exp_valid = 1'b0;
  logic              exp_ovf   = 1'b0;

  ir_prefetch_queue #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .wr_data    (wr_data),
    .advance    (advance),
    .flush      (flush),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
`ifdef IR_PREFETCH_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Drive one falling edge and update the expected model; DUT sampled 1 time unit after.
  task automatic step(input logic ld, input logic [WORD_W-1:0] d, input logic adv, input logic fl);
    int  sz;
    load = ld; wr_data = d; advance = adv; flush = fl;
    sz = sb.size();
    if (fl) begin
      sb.delete();
      exp_valid = 1'b0;
    end else begin
      if (adv) begin
        if (sz > 0) begin
          exp_ir = sb.pop_front();
          exp_valid = 1'b1;
        end else if (ld) begin
          exp_ir = d;
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
        end
      end
      if (ld && !(adv && sz == 0)) begin
        if (sz < DEPTH || adv) sb.push_back(d);
        else exp_ovf = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    load = 1'b0; advance = 1'b0; flush = 1'b0;
  endtask

  task automatic model_reset();
    sb.delete();
    exp_ir = '0; exp_valid = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks++; if (ir_out !== 8'h00) $display("FAIL por_ir_out got %h want 00", ir_out); else n_pass++;
    n_checks++; if (ir_valid !== 1'b0) $display("FAIL por_ir_valid got %b want 0", ir_valid); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL por_count got %0d want 0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL por_flags got e=%b f=%b want e=1 f=0", empty, full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL por_overflow got %b want 0", overflow); else n_pass++;
    rst = 1'b0;
    model_reset();
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (ir_out !== 8'hA1 || count !== 3'd1) $display("FAIL pre_rst got ir=%h cnt=%0d want ir=a1 cnt=1", ir_out, count); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ir_out !== 8'h00 || ir_valid !== 1'b0) $display("FAIL async_rst_ir got ir=%h v=%b want ir=00 v=0", ir_out, ir_valid); else n_pass++;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL async_rst_count got cnt=%0d e=%b want cnt=0 e=1", count, empty); else n_pass++;
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill_drain();
    logic [WORD_W-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1 || count !== 3'd4) $display("FAIL fill_full got f=%b cnt=%0d want f=1 cnt=4", full, count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++; if (ir_out !== exp_ir || ir_valid !== 1'b1) $display("FAIL drain_ir[%0d] got %h v=%b want %h v=1", i, ir_out, ir_valid, exp_ir); else n_pass++;
      n_checks++; if (count !== CNT_W'(3 - i)) $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 3 - i); else n_pass++;
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, 8'h61 + WORD_W'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd4) $display("FAIL ovf_count got %0d want 4", count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else n_pass++;
    step(1'b1, 8'h77, 1'b1, 1'b0);
    n_checks++; if (ir_out !== 8'h61 || count !== 3'd4) $display("FAIL full_push_pop got ir=%h cnt=%0d want ir=61 cnt=4", ir_out, count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++; if (ir_out !== exp_ir || ir_out === 8'h55) $display("FAIL ovf_drain[%0d] got %h want %h", i, ir_out, exp_ir); else n_pass++;
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (ir_valid !== 1'b0 || ir_out !== 8'h77) $display("FAIL starve got ir=%h v=%b want ir=77 v=0", ir_out, ir_valid); else n_pass++;
  endtask

  task automatic test_bypass();
    step(1'b1, 8'h7E, 1'b1, 1'b0);
    n_checks++; if (ir_out !== 8'h7E || ir_valid !== 1'b1) $display("FAIL bypass_ir got ir=%h v=%b want ir=7e v=1", ir_out, ir_valid); else n_pass++;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL bypass_count got cnt=%0d e=%b want cnt=0 e=1", count, empty); else n_pass++;
  endtask

  task automatic test_flush();
    step(1'b1, 8'hA0, 1'b0, 1'b0);
    step(1'b1, 8'hB0, 1'b0, 1'b0);
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    n_checks++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL flush_count got cnt=%0d e=%b want cnt=0 e=1", count, empty); else n_pass++;
    n_checks++; if (ir_valid !== 1'b0 || ir_out !== 8'h7E) $display("FAIL flush_ir got ir=%h v=%b want ir=7e v=0", ir_out, ir_valid); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL flush_overflow got %b want 1", overflow); else n_pass++;
    step(1'b1, 8'hD0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (ir_out !== 8'hD0 || count !== 3'd0) $display("FAIL post_flush got ir=%h cnt=%0d want ir=d0 cnt=0", ir_out, count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 9) < 6), WORD_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
      n_checks++; if (ir_out !== exp_ir || ir_valid !== exp_valid) $display("FAIL rnd_ir[%0d] got %h v=%b want %h v=%b", i, ir_out, ir_valid, exp_ir, exp_valid); else n_pass++;
      n_checks++; if (count !== CNT_W'(sb.size())) $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, sb.size()); else n_pass++;
      n_checks++; if (full !== (sb.size() == DEPTH) || empty !== (sb.size() == 0)) $display("FAIL rnd_flags[%0d] got f=%b e=%b size=%0d", i, full, empty, sb.size()); else n_pass++;
      n_checks++; if (overflow !== exp_ovf) $display("FAIL rnd_overflow[%0d] got %b want %b", i, overflow, exp_ovf); else n_pass++;
    end
  endtask

`ifdef IR_PREFETCH_PARITY_EN
  task automatic test_parity();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h35, 1'b0, 1'b0);
    step(1'b1, 8'h36, 1'b0, 1'b0);
    u_dut.u_mem.mem_q[0][WORD_W] = ~u_dut.u_mem.mem_q[0][WORD_W];
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (parity_err !== 1'b1 || ir_out !== 8'h35) $display("FAIL parity_bad got pe=%b ir=%h want pe=1 ir=35", parity_err, ir_out); else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (parity_err !== 1'b0 || ir_out !== 8'h36) $display("FAIL parity_clean got pe=%b ir=%h want pe=0 ir=36", parity_err, ir_out); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_bypass();
    test_flush();
`ifdef IR_PREFETCH_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
